// File: rtl/algo_refr_sched_mbnk_if.sv
// Bus between the algorithmic-memory core and its refresh scheduler.
//
// Handshake: en and blk_vld/blk_bank are sampled every cycle with no
// acknowledgement; blk_bank is meaningful only while blk_vld is high.
// refr_vld is a one-cycle pulse with no ready/backpressure; refr_bank,
// refr_row, refr_urg and refr_wrap are meaningful only while refr_vld
// is high (bank/row hold their last value otherwise). ready, debt and
// ovf are plain status levels.
interface algo_refr_sched_mbnk_if #(
  parameter int BITRBNK = 2,
  parameter int BITRROW = 8,
  parameter int BITDEBT = 2
);
  logic               en;
  logic               blk_vld;
  logic [BITRBNK-1:0] blk_bank;
  logic               ready;
  logic               refr_vld;
  logic [BITRBNK-1:0] refr_bank;
  logic [BITRROW-1:0] refr_row;
  logic               refr_urg;
  logic               refr_wrap;
  logic [BITDEBT-1:0] debt;
  logic               ovf;

  // core side
  modport master (
    output en, blk_vld, blk_bank,
    input  ready, refr_vld, refr_bank, refr_row, refr_urg, refr_wrap, debt, ovf
  );

  // scheduler side
  modport slave (
    input  en, blk_vld, blk_bank,
    output ready, refr_vld, refr_bank, refr_row, refr_urg, refr_wrap, debt, ovf
  );
endinterface

// File: rtl/algo_refr_sched_mbnk.sv
// DRAM refresh scheduler: fractional-rate refresh cadence, bank-then-row
// walk, deferral of refreshes that collide with a pending access on the
// same bank, bounded refresh debt and forced issue once debt is full.
module algo_refr_sched_mbnk #(
  parameter int NUMRBNK = 4,
  parameter int BITRBNK = 2,
  parameter int NUMRROW = 256,
  parameter int BITRROW = 8,
  parameter int REFFREQ = 6,
  parameter int REFFRHF = 0,
  parameter int MAXDEBT = 3,
  parameter int BITDEBT = 2
) (
  input logic                  clk,
  input logic                  rst,
  algo_refr_sched_mbnk_if.slave bus
);

  // icnt must reach REFFREQ when the long (REFFREQ+1) interval is in use
  localparam int BITICNT = $clog2(REFFREQ + 1);

  localparam logic [BITRBNK-1:0] LASTBNK = BITRBNK'(NUMRBNK - 1);
  localparam logic [BITRROW-1:0] LASTROW = BITRROW'(NUMRROW - 1);
  localparam logic [BITDEBT-1:0] DEBTMAX = BITDEBT'(MAXDEBT);
  localparam logic [BITICNT-1:0] ICNTLO  = BITICNT'(REFFREQ - 1);
  localparam logic [BITICNT-1:0] ICNTHI  = BITICNT'(REFFREQ);

  logic [BITICNT-1:0] icnt;
  logic               phase;
  logic [BITRBNK-1:0] bankPtr;
  logic [BITRROW-1:0] rowPtr;
  logic [BITDEBT-1:0] debtQ;
  logic               ovfQ;
  logic               readyQ;

  logic               refrVldQ;
  logic [BITRBNK-1:0] refrBankQ;
  logic [BITRROW-1:0] refrRowQ;
  logic               refrUrgQ;
  logic               refrWrapQ;

  logic [BITICNT-1:0] icntLast;
  logic               due;
  logic               atMax;
  logic               blocked;
  logic               issue;
  logic               urgent;
  logic               wrapNow;
  logic [BITDEBT-1:0] debtNext;

  // Issue decision from registered state and this cycle's inputs; a new
  // due only becomes issuable in the cycle after it is counted as debt.
  always_comb begin
    icntLast = ((REFFRHF != 0) && phase) ? ICNTHI : ICNTLO;
    due      = (icnt == icntLast);
    atMax    = (debtQ == DEBTMAX);
    blocked  = bus.blk_vld && (bus.blk_bank == bankPtr);
    issue    = bus.en && (debtQ != '0) && (atMax || !blocked);
    urgent   = issue && atMax;
    wrapNow  = issue && (bankPtr == LASTBNK) && (rowPtr == LASTROW);
    debtNext = debtQ;
    if (due && !issue && !atMax) begin
      debtNext = debtQ + 1'b1;
    end else if (!due && issue) begin
      debtNext = debtQ - 1'b1;
    end
  end

  // Interval counter; phase alternates short/long intervals when enabled
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      icnt  <= '0;
      phase <= 1'b0;
    end else if (due) begin
      icnt  <= '0;
      phase <= ~phase;
    end else begin
      icnt <= icnt + 1'b1;
    end
  end

  // Debt accounting, sticky overflow and the ready flag
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      debtQ  <= '0;
      ovfQ   <= 1'b0;
      readyQ <= 1'b0;
    end else begin
      readyQ <= 1'b1;
      debtQ  <= debtNext;
      if (due && atMax && !issue) begin
        ovfQ <= 1'b1;
      end
    end
  end

  // Bank-then-row walk and the registered issue outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bankPtr   <= '0;
      rowPtr    <= '0;
      refrVldQ  <= 1'b0;
      refrBankQ <= '0;
      refrRowQ  <= '0;
      refrUrgQ  <= 1'b0;
      refrWrapQ <= 1'b0;
    end else begin
      refrVldQ  <= issue;
      refrUrgQ  <= urgent;
      refrWrapQ <= wrapNow;
      if (issue) begin
        refrBankQ <= bankPtr;
        refrRowQ  <= rowPtr;
        if (bankPtr == LASTBNK) begin
          bankPtr <= '0;
          rowPtr  <= (rowPtr == LASTROW) ? '0 : rowPtr + 1'b1;
        end else begin
          bankPtr <= bankPtr + 1'b1;
        end
      end
    end
  end

  assign bus.ready     = readyQ;
  assign bus.refr_vld  = refrVldQ;
  assign bus.refr_bank = refrBankQ;
  assign bus.refr_row  = refrRowQ;
  assign bus.refr_urg  = refrUrgQ;
  assign bus.refr_wrap = refrWrapQ;
  assign bus.debt      = debtQ;
  assign bus.ovf       = ovfQ;

endmodule

// File: tb/tb_algo_refr_sched_mbnk.sv
// Bench for algo_refr_sched_mbnk: default-parameter instance driven through
// cadence, blocking, debt, sweep-wrap and mid-cycle reset scenarios, plus a
// REFFRHF=1 instance checked for alternating 6/7 issue spacing.
`timescale 1ns/1ps
module tb_algo_refr_sched_mbnk;
  localparam int BITRBNK = 2;
  localparam int BITRROW = 8;
  localparam int BITDEBT = 2;
  localparam int EW      = BITRBNK + BITRROW + 2;

  logic clk = 1'b0;
  logic rst;
  logic rstHf;
  int   cyc = 0;
  int   relCyc = 0;
  int   hfRel = 0;
  int   nChecks = 0;
  int   nPass = 0;
  int   issueCnt = 0;
  int   maxDebtSeen = 0;
  bit   hfDone = 1'b0;
  logic [EW-1:0] exp_q[$];
  logic [EW-1:0] monExp;

  // clock / cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  algo_refr_sched_mbnk_if #(.BITRBNK(BITRBNK), .BITRROW(BITRROW), .BITDEBT(BITDEBT)) bus ();
  algo_refr_sched_mbnk_if #(.BITRBNK(BITRBNK), .BITRROW(BITRROW), .BITDEBT(BITDEBT)) busHf ();

  algo_refr_sched_mbnk #(
    .NUMRBNK(4), .BITRBNK(BITRBNK), .NUMRROW(256), .BITRROW(BITRROW),
    .REFFREQ(6), .REFFRHF(0), .MAXDEBT(3), .BITDEBT(BITDEBT)
  ) dut (.clk(clk), .rst(rst), .bus(bus));

  algo_refr_sched_mbnk #(
    .NUMRBNK(4), .BITRBNK(BITRBNK), .NUMRROW(256), .BITRROW(BITRROW),
    .REFFREQ(6), .REFFRHF(1), .MAXDEBT(3), .BITDEBT(BITDEBT)
  ) dutHf (.clk(clk), .rst(rstHf), .bus(busHf));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    nChecks++;
    if (got === want) nPass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, want, $time);
  endtask

  function automatic logic [EW-1:0] packExp(input int b, input int r, input bit u, input bit w);
    return {BITRBNK'(b), BITRROW'(r), u, w};
  endfunction

  // scoreboard: every issue pulse pops one expected {bank,row,urg,wrap}
  always @(negedge clk) begin
    if (bus.refr_vld === 1'b1) begin
      issueCnt++;
      if (exp_q.size() == 0) begin
        check("unexpIssue", 32'd1, 32'd0);
      end else begin
        monExp = exp_q.pop_front();
        check($sformatf("issue%0d", issueCnt),
              32'({bus.refr_bank, bus.refr_row, bus.refr_urg, bus.refr_wrap}), 32'(monExp));
      end
    end
  end

  task automatic doReset();
    rst          = 1'b0;
    bus.en       = 1'b0;
    bus.blk_vld  = 1'b0;
    bus.blk_bank = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rstReady", 32'(bus.ready), 32'd0);
    check("rstVld",   32'(bus.refr_vld), 32'd0);
    check("rstDebt",  32'(bus.debt), 32'd0);
    check("rstOvf",   32'(bus.ovf), 32'd0);
    exp_q.delete();
  endtask

  task automatic releaseRst();
    @(negedge clk);
    rst    = 1'b1;
    relCyc = cyc;
  endtask

  // wait until the DUT has seen edge k after reset release, then settle
  task automatic waitEdges(input int k);
    while ((cyc - relCyc) < k) @(negedge clk);
    #1;
  endtask

  // wait for the next issue pulse; returns the edge index after release
  task automatic waitIssue(input string tag, input int limit, output int at, output bit ok);
    ok = 1'b0;
    at = -1;
    for (int k = 0; k < limit; k++) begin
      @(negedge clk);
      #1;
      if (int'(bus.debt) > maxDebtSeen) maxDebtSeen = int'(bus.debt);
      if (bus.refr_vld === 1'b1) begin
        ok = 1'b1;
        at = cyc - relCyc;
        break;
      end
    end
    if (!ok) check({tag, "Timeout"}, 32'd0, 32'd1);
  endtask

  // REFFRHF=1 instance: spacings alternate 7,6,7,... after the first issue
  initial begin
    int  hfT[20];
    int  sp;
    int  cnt;
    bit  seen;
    rstHf          = 1'b0;
    busHf.en       = 1'b0;
    busHf.blk_vld  = 1'b0;
    busHf.blk_bank = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rstHf    = 1'b1;
    hfRel    = cyc;
    busHf.en = 1'b1;
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      seen = 1'b0;
      for (int k = 0; k < 20; k++) begin
        @(negedge clk);
        #1;
        if (busHf.refr_vld === 1'b1) begin
          seen = 1'b1;
          break;
        end
      end
      if (!seen) begin
        check("hfTimeout", 32'd0, 32'd1);
        break;
      end
      hfT[i] = cyc - hfRel;
      cnt++;
    end
    if (cnt == 20) begin
      for (int i = 1; i < 20; i++) begin
        sp = hfT[i] - hfT[i-1];
        check($sformatf("hfSpacing%0d", i), 32'(sp), (i % 2 == 1) ? 32'd7 : 32'd6);
      end
      check("hfSpan20", 32'(hfT[19] >= 129 && hfT[19] <= 131), 32'd1);
    end
    busHf.en = 1'b0;
    hfDone   = 1'b1;
  end

  initial begin
    int at;
    int prev;
    bit ok;
    int base;

    // test 1: steady cadence, blocks on other banks never defer
    doReset();
    releaseRst();
    bus.en = 1'b1;
    for (int i = 0; i < 5; i++) exp_q.push_back(packExp(i % 4, i / 4, 1'b0, 1'b0));
    maxDebtSeen = 0;
    prev = 0;
    for (int i = 0; i < 5; i++) begin
      bus.blk_vld  = 1'b1;
      bus.blk_bank = BITRBNK'((i + 2) % 4);
      waitIssue("t1", 20, at, ok);
      if (!ok) break;
      if (i == 0) check("t1Latency", 32'(at >= 6 && at <= 7), 32'd1);
      else check($sformatf("t1Spacing%0d", i), 32'(at - prev), 32'd6);
      prev = at;
    end
    check("t1DebtMax", 32'(maxDebtSeen <= 1), 32'd1);
    bus.en      = 1'b0;
    bus.blk_vld = 1'b0;
    check("t1QueueEmpty", 32'(exp_q.size()), 32'd0);

    // test 3: blocked bank 0 builds debt, then a forced urgent issue
    doReset();
    releaseRst();
    base         = issueCnt;
    bus.en       = 1'b1;
    bus.blk_vld  = 1'b1;
    bus.blk_bank = '0;
    waitEdges(6);
    check("t3Debt1", 32'(bus.debt), 32'd1);
    waitEdges(12);
    check("t3Debt2", 32'(bus.debt), 32'd2);
    waitEdges(18);
    check("t3Debt3", 32'(bus.debt), 32'd3);
    check("t3NoIssueYet", 32'(issueCnt - base), 32'd0);
    exp_q.push_back(packExp(0, 0, 1'b1, 1'b0));
    exp_q.push_back(packExp(1, 0, 1'b0, 1'b0));
    exp_q.push_back(packExp(2, 0, 1'b0, 1'b0));
    waitIssue("t3a", 10, at, ok);
    check("t3ForcedEdge", 32'(at), 32'd19);
    waitIssue("t3b", 5, at, ok);
    check("t3SecondEdge", 32'(at), 32'd20);
    waitIssue("t3c", 5, at, ok);
    check("t3ThirdEdge", 32'(at), 32'd21);
    bus.en      = 1'b0;
    bus.blk_vld = 1'b0;
    check("t3QueueEmpty", 32'(exp_q.size()), 32'd0);

    // test 4: en low saturates debt and sets ovf, then drains back-to-back
    doReset();
    releaseRst();
    waitEdges(17);
    check("t4Debt2", 32'(bus.debt), 32'd2);
    waitEdges(18);
    check("t4Debt3", 32'(bus.debt), 32'd3);
    check("t4OvfClear18", 32'(bus.ovf), 32'd0);
    waitEdges(23);
    check("t4OvfClear23", 32'(bus.ovf), 32'd0);
    waitEdges(24);
    check("t4OvfSet", 32'(bus.ovf), 32'd1);
    waitEdges(30);
    check("t4DebtSat", 32'(bus.debt), 32'd3);
    exp_q.push_back(packExp(0, 0, 1'b1, 1'b0));
    exp_q.push_back(packExp(1, 0, 1'b0, 1'b0));
    exp_q.push_back(packExp(2, 0, 1'b0, 1'b0));
    bus.en = 1'b1;
    waitIssue("t4a", 5, at, ok);
    check("t4FirstEdge", 32'(at), 32'd31);
    prev = at;
    for (int i = 1; i < 3; i++) begin
      waitIssue("t4b", 5, at, ok);
      check($sformatf("t4BackToBack%0d", i), 32'(at - prev), 32'd1);
      prev = at;
    end
    bus.en = 1'b0;
    check("t4DebtDrained", 32'(bus.debt), 32'd0);
    check("t4OvfSticky", 32'(bus.ovf), 32'd1);
    check("t4QueueEmpty", 32'(exp_q.size()), 32'd0);

    // test 5: full sweep, wrap on issue 1024, restart on issue 1025
    doReset();
    releaseRst();
    bus.en = 1'b1;
    for (int i = 0; i < 1025; i++)
      exp_q.push_back(packExp(i % 4, (i / 4) % 256, 1'b0, i == 1023));
    for (int i = 0; i < 1025; i++) begin
      waitIssue("t5", 20, at, ok);
      if (!ok) break;
    end
    bus.en = 1'b0;
    check("t5QueueEmpty", 32'(exp_q.size()), 32'd0);

    // test 6: asynchronous reset mid-cycle with debt and advanced pointers
    doReset();
    releaseRst();
    bus.en = 1'b1;
    for (int i = 0; i < 22; i++) exp_q.push_back(packExp(i % 4, i / 4, 1'b0, 1'b0));
    for (int i = 0; i < 22; i++) begin
      waitIssue("t6", 20, at, ok);
      if (!ok) break;
    end
    bus.blk_vld  = 1'b1;
    bus.blk_bank = 2'd2;
    waitEdges(144);
    check("t6DebtBefore", 32'(bus.debt), 32'd2);
    check("t6BankBefore", 32'(bus.refr_bank), 32'd1);
    check("t6RowBefore", 32'(bus.refr_row), 32'd5);
    @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    check("t6AsyncReady", 32'(bus.ready), 32'd0);
    check("t6AsyncDebt", 32'(bus.debt), 32'd0);
    check("t6AsyncBank", 32'(bus.refr_bank), 32'd0);
    check("t6AsyncRow", 32'(bus.refr_row), 32'd0);
    check("t6AsyncVld", 32'(bus.refr_vld), 32'd0);
    bus.blk_vld = 1'b0;
    repeat (2) @(posedge clk);
    releaseRst();
    exp_q.push_back(packExp(0, 0, 1'b0, 1'b0));
    waitIssue("t6Post", 20, at, ok);
    check("t6PostLatency", 32'(at >= 6 && at <= 7), 32'd1);
    bus.en = 1'b0;
    check("t6QueueEmpty", 32'(exp_q.size()), 32'd0);

    // final report
    for (int k = 0; k < 2000 && !hfDone; k++) @(negedge clk);
    check("hfDone", 32'(hfDone), 32'd1);
    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end
endmodule
